// File: rtl/saturn_bus_sequencer_pkg.sv
// saturn_bus_pkg: shared definitions for the Saturn bus sequencer.
//   - phase indices into the one-hot i_phases strobe (P0..P3)
//   - position of the command/data flag in a program queue entry
//   - sequencer slot state encoding
package saturn_bus_pkg;

  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;
  localparam int unsigned P2 = 2;
  localparam int unsigned P3 = 3;

  // The command flag sits directly above the nibble in each queue entry.
  function automatic int unsigned cmd_flag_pos(input int unsigned nibble_w);
    return nibble_w;
  endfunction

  localparam int unsigned CMD_FLAG = cmd_flag_pos(4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_READ = 2'd2
  } state_t;

endpackage

// File: rtl/saturn_bus_sequencer_prog_fifo.sv
// saturn_bus_prog_fifo: single-clock synchronous FIFO holding program entries.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_push/i_push_data write one entry (accepted when not full, or when a pop
//                      happens in the same clock)
//   i_pop              remove the head entry (ignored when empty)
//   o_pop_data         head entry (show-ahead, valid while !o_empty)
//   o_full, o_empty    occupancy flags
//   o_level            occupancy, 0..DEPTH
//   o_overflow         push dropped this clock because the FIFO was full
module saturn_bus_prog_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_level == FULL_LVL);
  assign w_empty   = (r_level == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same clock frees the slot, so a push at full still lands.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_level    = r_level;
  assign o_overflow = i_push && !w_do_push;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + (AW+1)'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/saturn_bus_sequencer.sv
// saturn_bus_sequencer: replays a queue of command/data nibbles on the 4-phase
// Saturn nibble bus (one nibble per bus cycle) and runs multi-nibble read
// bursts when the queue is empty.
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_clk_en, i_phases       bus clock enable and one-hot phase strobe P0..P3
//   i_prog_wr, i_prog_data   program queue push ({cmd_flag, nibble})
//   o_prog_full, o_prog_level queue status
//   i_read_req, i_read_count start a read burst of i_read_count nibbles
//   o_read_valid/_nibble/_done captured nibble strobe, last-nibble strobe
//   o_bus_clk_en, o_bus_is_data, o_bus_nibble_out, i_bus_nibble_in  bus side
//   o_busy                   queue non-empty or burst outstanding (updated at P2)
//   o_error, i_error_clear   sticky protocol error (overflow / rejected read)
module saturn_bus_sequencer
  import saturn_bus_pkg::*;
#(
  parameter int unsigned NIBBLE_W   = 4,
  parameter int unsigned PROG_DEPTH = 32,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_clk_en,
  input  logic [3:0]                    i_phases,
  input  logic                          i_prog_wr,
  input  logic [NIBBLE_W:0]             i_prog_data,
  output logic                          o_prog_full,
  output logic [$clog2(PROG_DEPTH):0]   o_prog_level,
  input  logic                          i_read_req,
  input  logic [CNT_W-1:0]              i_read_count,
  output logic                          o_read_valid,
  output logic [NIBBLE_W-1:0]           o_read_nibble,
  output logic                          o_read_done,
  output logic                          o_bus_clk_en,
  output logic                          o_bus_is_data,
  output logic [NIBBLE_W-1:0]           o_bus_nibble_out,
  input  logic [NIBBLE_W-1:0]           i_bus_nibble_in,
  output logic                          o_busy,
  output logic                          o_error,
  input  logic                          i_error_clear
);

  localparam int unsigned CMD_BIT = cmd_flag_pos(NIBBLE_W);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;

  logic [NIBBLE_W:0]  w_head;
  logic               w_empty;
  logic               w_overflow;
  logic               w_act;
  logic               w_p0;
  logic               w_p1;
  logic               w_p2;
  logic               w_pop;
  logic               w_req_valid;
  logic               w_req_reject;

  // Malformed (non one-hot) phase strobes are treated as "no phase".
  assign w_act = i_clk_en && $onehot(i_phases);
  assign w_p0  = w_act && i_phases[P0];
  assign w_p1  = w_act && i_phases[P1];
  assign w_p2  = w_act && i_phases[P2];
  assign w_pop = w_p0 && !w_empty;

  assign w_req_valid  = i_read_req && (i_read_count != '0);
  assign w_req_reject = w_req_valid && (r_cnt != '0);

  saturn_bus_prog_fifo #(
    .WIDTH (NIBBLE_W + 1),
    .DEPTH (PROG_DEPTH)
  ) u_prog_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (i_prog_wr),
    .i_push_data (i_prog_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (o_prog_full),
    .o_empty     (w_empty),
    .o_level     (o_prog_level),
    .o_overflow  (w_overflow)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      o_read_valid     <= 1'b0;
      o_read_nibble    <= '0;
      o_read_done      <= 1'b0;
      o_bus_clk_en     <= 1'b0;
      o_bus_is_data    <= 1'b0;
      o_bus_nibble_out <= '0;
      o_busy           <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      o_read_valid <= 1'b0;
      o_read_done  <= 1'b0;

      // Load and decrement never coincide: load needs r_cnt==0, the P1
      // decrement needs r_cnt!=0.
      if (w_req_valid && (r_cnt == '0)) begin
        r_cnt <= i_read_count;
      end

      if (w_p0) begin
        if (!w_empty) begin
          r_state          <= ST_SEND;
          o_bus_clk_en     <= 1'b1;
          o_bus_is_data    <= !w_head[CMD_BIT];
          o_bus_nibble_out <= w_head[NIBBLE_W-1:0];
        end else if (r_cnt != '0) begin
          r_state       <= ST_READ;
          o_bus_clk_en  <= 1'b1;
          o_bus_is_data <= 1'b1;
        end else begin
          r_state <= ST_IDLE;
        end
      end

      if (w_p1) begin
        o_bus_clk_en <= 1'b0;
        if ((r_state == ST_READ) && (r_cnt != '0)) begin
          o_read_nibble <= i_bus_nibble_in;
          o_read_valid  <= 1'b1;
          r_cnt         <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            o_read_done <= 1'b1;
          end
        end
      end

      if (w_p2) begin
        o_busy <= !w_empty || (r_cnt != '0);
      end

      if (i_error_clear) begin
        o_error <= 1'b0;
      end else if (w_overflow || w_req_reject) begin
        o_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_saturn_bus_sequencer.sv
module tb_saturn_bus_sequencer;

  localparam logic [3:0] PH0 = 4'b0001;
  localparam logic [3:0] PH1 = 4'b0010;
  localparam logic [3:0] PH2 = 4'b0100;
  localparam logic [3:0] PH3 = 4'b1000;
  localparam logic [3:0] PHN = 4'b0000;

  logic       clk = 1'b0;
  logic       i_reset, i_clk_en, i_prog_wr, i_read_req, i_error_clear;
  logic [3:0] i_phases;
  logic [4:0] i_prog_data;
  logic [4:0] i_read_count;
  logic [3:0] i_bus_nibble_in;
  logic       o_prog_full, o_read_valid, o_read_done, o_bus_clk_en;
  logic       o_bus_is_data, o_busy, o_error;
  logic [5:0] o_prog_level;
  logic [3:0] o_read_nibble, o_bus_nibble_out;

  always #5 clk = ~clk;

  saturn_bus_sequencer #(
    .NIBBLE_W   (4),
    .PROG_DEPTH (32),
    .CNT_W      (5)
  ) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_clk_en         (i_clk_en),
    .i_phases         (i_phases),
    .i_prog_wr        (i_prog_wr),
    .i_prog_data      (i_prog_data),
    .o_prog_full      (o_prog_full),
    .o_prog_level     (o_prog_level),
    .i_read_req       (i_read_req),
    .i_read_count     (i_read_count),
    .o_read_valid     (o_read_valid),
    .o_read_nibble    (o_read_nibble),
    .o_read_done      (o_read_done),
    .o_bus_clk_en     (o_bus_clk_en),
    .o_bus_is_data    (o_bus_is_data),
    .o_bus_nibble_out (o_bus_nibble_out),
    .i_bus_nibble_in  (i_bus_nibble_in),
    .o_busy           (o_busy),
    .o_error          (o_error),
    .i_error_clear    (i_error_clear)
  );

  typedef struct { logic rd; logic is_data; logic [3:0] nib; } slot_t;
  typedef struct { logic [3:0] nib; logic done; } rd_t;
  typedef struct { logic [4:0] din; logic exp_is_data; logic [3:0] exp_nib; } wvec_t;
  typedef struct { logic [3:0] bus; logic exp_done; } rvec_t;

  slot_t      exp_bus[$];
  rd_t        exp_rd[$];
  logic [3:0] bus_src[$];

  int checks = 0;
  int errors = 0;
  logic [3:0] last_ph = 4'b0000;
  logic       prev_bce = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] ph, input logic en);
    i_phases = ph;
    i_clk_en = en;
    @(posedge clk);
    last_ph = ph;
    #1;
  endtask

  task automatic push(input logic [4:0] d, input logic en);
    i_prog_wr   = 1'b1;
    i_prog_data = d;
    step(PHN, en);
    i_prog_wr   = 1'b0;
  endtask

  task automatic read_req(input logic [4:0] n);
    i_read_req   = 1'b1;
    i_read_count = n;
    step(PHN, 1'b1);
    i_read_req   = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      step(PH0, 1'b1);
      step(PH1, 1'b1);
      step(PH2, 1'b1);
      step(PH3, 1'b1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bce"},   o_bus_clk_en, 0);
    chk({tag, "_isd"},   o_bus_is_data, 0);
    chk({tag, "_bnib"},  o_bus_nibble_out, 0);
    chk({tag, "_rv"},    o_read_valid, 0);
    chk({tag, "_rnib"},  o_read_nibble, 0);
    chk({tag, "_done"},  o_read_done, 0);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_err"},   o_error, 0);
    chk({tag, "_full"},  o_prog_full, 0);
    chk({tag, "_level"}, o_prog_level, 0);
  endtask

  // Scoreboard side: bus slots and read strobes are matched against queues
  // filled when the stimulus was driven.
  always @(negedge clk) begin
    slot_t s;
    rd_t   r;
    if (o_bus_clk_en) begin
      chk("bce_after_p0", last_ph, PH0);
    end
    if (o_bus_clk_en && !prev_bce) begin
      if (exp_bus.size() == 0) begin
        chk("unexpected_slot", 1, 0);
      end else begin
        s = exp_bus.pop_front();
        chk("slot_is_data", o_bus_is_data, s.is_data);
        if (!s.rd) chk("slot_nibble", o_bus_nibble_out, s.nib);
      end
    end
    prev_bce = o_bus_clk_en;
    if (o_read_valid) begin
      if (exp_rd.size() == 0) begin
        chk("unexpected_read", 1, 0);
      end else begin
        r = exp_rd.pop_front();
        chk("read_nibble", o_read_nibble, r.nib);
        chk("read_done", o_read_done, r.done);
      end
      if (bus_src.size() > 0) void'(bus_src.pop_front());
    end else if (o_read_done) begin
      chk("done_without_valid", 1, 0);
    end
    i_bus_nibble_in = (bus_src.size() > 0) ? bus_src[0] : 4'h0;
  end

  initial begin
    wvec_t wv[3];
    rvec_t rv[3];
    logic [4:0] d;

    wv[0] = '{5'h15, 1'b0, 4'h5};
    wv[1] = '{5'h03, 1'b1, 4'h3};
    wv[2] = '{5'h0A, 1'b1, 4'hA};
    rv[0] = '{4'h1, 1'b0};
    rv[1] = '{4'h2, 1'b0};
    rv[2] = '{4'hF, 1'b1};

    i_reset = 1'b1; i_clk_en = 1'b0; i_phases = PHN; i_prog_wr = 1'b0;
    i_prog_data = '0; i_read_req = 1'b0; i_read_count = '0;
    i_error_clear = 1'b0; i_bus_nibble_in = '0;
    repeat (3) step(PHN, 1'b0);
    chk_all_zero("reset");
    i_reset = 1'b0;

    // Plain replay: cmd 5, data 3, data A.
    for (int i = 0; i < 3; i++) begin
      push(wv[i].din, 1'b1);
      exp_bus.push_back('{1'b0, wv[i].exp_is_data, wv[i].exp_nib});
    end
    chk("send_level", o_prog_level, 3);
    run_cycles(1);
    chk("send_busy_mid", o_busy, 1);
    run_cycles(2);
    chk("send_busy_end", o_busy, 0);
    chk("send_slots_left", exp_bus.size(), 0);

    // Read burst of 3.
    for (int i = 0; i < 3; i++) begin
      bus_src.push_back(rv[i].bus);
      exp_rd.push_back('{rv[i].bus, rv[i].exp_done});
      exp_bus.push_back('{1'b1, 1'b1, 4'h0});
    end
    read_req(5'd3);
    run_cycles(4);
    chk("read_left", exp_rd.size(), 0);
    chk("read_err", o_error, 0);
    chk("read_busy", o_busy, 0);

    // Fill with clock enable off, then overflow.
    for (int i = 0; i < 32; i++) begin
      d = {(i % 3 == 0) ? 1'b1 : 1'b0, 4'((i * 5 + 3) % 16)};
      push(d, 1'b0);
      exp_bus.push_back('{1'b0, !d[4], d[3:0]});
    end
    chk("full_flag", o_prog_full, 1);
    chk("full_level", o_prog_level, 32);
    chk("full_err_pre", o_error, 0);
    push(5'h1E, 1'b0);
    chk("ovf_err", o_error, 1);
    chk("ovf_level", o_prog_level, 32);
    i_error_clear = 1'b1;
    push(5'h1D, 1'b0);
    i_error_clear = 1'b0;
    chk("clr_priority_err", o_error, 0);
    chk("clr_priority_level", o_prog_level, 32);
    // Push and pop in the same clock at full.
    i_prog_wr = 1'b1; i_prog_data = 5'h07;
    step(PH0, 1'b1);
    i_prog_wr = 1'b0;
    exp_bus.push_back('{1'b0, 1'b1, 4'h7});
    chk("pushpop_level", o_prog_level, 32);
    chk("pushpop_err", o_error, 0);
    step(PH1, 1'b1); step(PH2, 1'b1); step(PH3, 1'b1);
    run_cycles(32);
    chk("drain_level", o_prog_level, 0);
    chk("drain_busy", o_busy, 0);
    chk("drain_slots_left", exp_bus.size(), 0);

    // Burst of 2 preempted by a command after the first nibble.
    bus_src.push_back(4'h6); bus_src.push_back(4'h9);
    exp_rd.push_back('{4'h6, 1'b0}); exp_rd.push_back('{4'h9, 1'b1});
    exp_bus.push_back('{1'b1, 1'b1, 4'h0});
    read_req(5'd2);
    run_cycles(1);
    push(5'h18, 1'b1);
    exp_bus.push_back('{1'b0, 1'b0, 4'h8});
    exp_bus.push_back('{1'b1, 1'b1, 4'h0});
    run_cycles(3);
    chk("preempt_slots_left", exp_bus.size(), 0);
    chk("preempt_reads_left", exp_rd.size(), 0);

    // Clock enable held low mid-queue.
    push(5'h0A, 1'b1); push(5'h0B, 1'b1); push(5'h1C, 1'b1);
    exp_bus.push_back('{1'b0, 1'b1, 4'hA});
    exp_bus.push_back('{1'b0, 1'b1, 4'hB});
    exp_bus.push_back('{1'b0, 1'b0, 4'hC});
    run_cycles(1);
    for (int k = 0; k < 10; k++) begin
      step(4'(1) << (k % 4), 1'b0);
      chk("hold_level", o_prog_level, 2);
      chk("hold_bce", o_bus_clk_en, 0);
    end
    run_cycles(2);
    chk("hold_slots_left", exp_bus.size(), 0);

    // Reset during P1 of a READ slot.
    read_req(5'd4);
    read_req(5'd2);
    chk("reject_err", o_error, 1);
    exp_bus.push_back('{1'b1, 1'b1, 4'h0});
    step(PH0, 1'b1);
    i_reset = 1'b1;
    step(PH1, 1'b1);
    i_reset = 1'b0;
    chk_all_zero("midreset");
    step(PH2, 1'b1); step(PH3, 1'b1);
    run_cycles(2);
    chk("post_reset_busy", o_busy, 0);
    chk("final_slots_left", exp_bus.size(), 0);
    chk("final_reads_left", exp_rd.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/saturn_bus_sequencer.md
Name: saturn_bus_sequencer

Overview:
- Parametrised successor to the 4-phase Saturn bus controller. A producer (control unit or debugger) loads a queue of command/data nibbles, and the block replays them on the bus, one nibble per 4-phase cycle.
- Adds multi-nibble read bursts with per-nibble capture and completion strobes.
- Adds queue-level reporting and a sticky protocol-error flag.
- Sits between the control unit and the external nibble bus. Runs on the gated bus clock enable.

Parameters:
- NIBBLE_W, 4, bus data width in bits.
- PROG_DEPTH, 32, program queue depth in entries; must be a power of 2, minimum 2.
- CNT_W, 5, width of the read burst counter.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clk_en  in  1  bus clock enable; all phase actions qualify on it.
- i_phases  in  4  one-hot phase strobe, P0..P3.
- i_prog_wr  in  1  push one entry into the program queue.
- i_prog_data  in  NIBBLE_W+1  bit NIBBLE_W: 1=command, 0=data; low bits: nibble.
- o_prog_full  out  1  queue full.
- o_prog_level  out  log2(PROG_DEPTH)+1  current queue occupancy.
- i_read_req  in  1  one-clock request to start a read burst.
- i_read_count  in  CNT_W  number of nibbles in the burst; 0 = request ignored.
- o_read_valid  out  1  one-clock strobe: o_read_nibble is valid.
- o_read_nibble  out  NIBBLE_W  captured bus nibble.
- o_read_done  out  1  one-clock strobe with the last nibble of a burst.
- o_bus_clk_en  out  1  bus strobe.
- o_bus_is_data  out  1  1=data, 0=command.
- o_bus_nibble_out  out  NIBBLE_W  nibble driven on the bus.
- i_bus_nibble_in  in  NIBBLE_W  nibble read from the bus.
- o_busy  out  1  queue non-empty or burst pending/active.
- o_error  out  1  sticky protocol error.
- i_error_clear  in  1  clears o_error.

Behaviour:
- Reset values: every output 0, queue empty, read counter 0, state IDLE. Reset mid-transaction aborts it; o_bus_clk_en is 0 on the next clock; no done strobe is issued.
- Queue pushes are accepted on any clock, independent of i_clk_en.
  - Push while full and no pop in the same clock: entry dropped, o_error set.
  - Push and pop in the same clock at full: both take effect; level is unchanged.
- State machine: IDLE, SEND, READ. State changes only on P0 with i_clk_en.
- P0 slot priority:
  - Queue non-empty: pop one entry, go to SEND. o_bus_clk_en<=1, o_bus_is_data<=!data[NIBBLE_W], o_bus_nibble_out<=data[NIBBLE_W-1:0].
  - Else, read counter >0: go to READ. o_bus_clk_en<=1, o_bus_is_data<=1.
  - Else: go to IDLE, no strobe.
- P1:
  - o_bus_clk_en<=0.
  - If the slot is READ: o_read_nibble<=i_bus_nibble_in, o_read_valid pulses for 1 clock, counter decrements.
  - When the counter goes 1->0, o_read_done pulses in the same clock.
- P2: o_busy recomputed, then held until the next P2. P3: no action.
- Read latency: nibble valid on the clock after the P1 edge of its slot; a burst of N nibbles takes N bus cycles after the queue drains.
- i_read_req:
  - Counter 0: load i_read_count.
  - Counter nonzero: request ignored, o_error set.
  - Accepted while the queue is non-empty: the burst waits until the queue drains.
- Writes always preempt pending reads at each P0 slot. A push arriving mid-burst suspends the burst after the current nibble.
- i_error_clear has priority over a same-clock error set.
- Level and counter arithmetic is unsigned and never wraps. Pointers wrap modulo PROG_DEPTH.

Decomposition:
- Shared package saturn_bus_pkg holds:
  - phase index constants P0..P3;
  - CMD_FLAG bit position;
  - state encoding IDLE/SEND/READ.
- One sub-module, saturn_bus_prog_fifo: synchronous single-clock FIFO with push, pop, full, empty and level outputs, parametrised on width and depth.

Test Plan:
- Push cmd 0x5, data 0x3, data 0xA with i_clk_en=1. Required:
  - bus shows (is_data=0, 5), then (1, 3), then (1, A) on 3 consecutive P0;
  - o_bus_clk_en high only between P0 and P1;
  - o_busy drops at the P2 after the last slot.
- i_read_req with count=3, queue empty, bus returns 0x1, 0x2, 0xF. Required: three o_read_valid strobes carrying 1, 2, F; o_read_done is coincident with F.
- Push 32 entries with i_clk_en=0, then a 33rd. Required: o_prog_full=1, level=32, o_error=1, the extra entry is absent from the replay.
- Issue a read burst of count 2, then push cmd 0x8 after the first nibble. Required: slot order read, cmd 8, read; o_read_done on the second nibble.
- Hold i_clk_en=0 for 10 clocks mid-queue. Required: no phase actions, outputs stable, replay resumes unchanged.
- Assert i_reset in P1 of a READ slot with count=4. Required: all outputs 0 next clock, no o_read_done, level=0, o_error=0.
